// File: rtl/uv_nb_store.sv
// uv_nb_store: chroma neighbour store that feeds the VP8 UV mode picker its top/left/corner context.
// Define UV_NB_ERR_EN to flag out-of-range columns and starts issued while busy on err.
module uv_nb_store #(
    parameter int MB_W_MAX = 128,
    localparam int AW = $clog2(MB_W_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          st_start,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [1023:0] src,
    output logic [63:0]   top_u,
    output logic [63:0]   top_v,
    output logic [63:0]   left_u,
    output logic [63:0]   left_v,
    output logic [7:0]    top_left_u,
    output logic [7:0]    top_left_v,
    output logic          ld_done,
    output logic          st_done,
    output logic          busy,
    output logic          err,
    output logic [2:0]    dbg_state
);
    // Handshake: ld_start/st_start are single-cycle requests honoured only while busy is low;
    // ld_done/st_done are single-cycle completion pulses, and context outputs hold after ld_done.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_CAP  = 3'd2,
        LD_DONE = 3'd3,
        ST_RD   = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [10:0] X_LIM = 11'(MB_W_MAX);

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic [9:0]    cx_q, cx_d, cy_q, cy_d;
    logic [127:0]  row_q, row_d;
    logic [63:0]   new_lu_q, new_lu_d, new_lv_q, new_lv_d;
    logic [63:0]   lu_q, lu_d, lv_q, lv_d;
    logic [7:0]    tlu_q, tlu_d, tlv_q, tlv_d;
    logic [63:0]   top_u_q, top_u_d, top_v_q, top_v_d;
    logic [63:0]   left_u_q, left_u_d, left_v_q, left_v_d;
    logic [7:0]    top_left_u_q, top_left_u_d, top_left_v_q, top_left_v_d;
    logic          err_q, err_d;
    logic          ram_re, ram_we, cx_ok;
    logic [AW-1:0] ram_addr;
    logic [127:0]  ram_dout_q;
    logic [127:0]  mem [MB_W_MAX];

`ifdef UV_NB_ERR_EN
    assign cx_ok = {1'b0, cx_q} < X_LIM;
`else
    assign cx_ok = 1'b1;
`endif

    // Top-row RAM: one bottom-row entry per column, not cleared by reset.
    assign ram_addr = cx_q[AW-1:0];
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= row_q;
        if (ram_re) ram_dout_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (st_start)      state_d = ST_RD;
                else if (ld_start) state_d = LD_RD;
            end
            LD_RD:   state_d = LD_CAP;
            LD_CAP:  state_d = LD_DONE;
            LD_DONE: state_d = IDLE;
            ST_RD:   state_d = ST_WR;
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = pend_q ? LD_RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_re  = 1'b0;
        ram_we  = 1'b0;
        ld_done = 1'b0;
        st_done = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            LD_RD, ST_RD: ram_re  = cx_ok;
            ST_WR:        ram_we  = cx_ok;
            LD_DONE:      ld_done = 1'b1;
            ST_DONE:      st_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pend_d       = pend_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        row_d        = row_q;
        new_lu_d     = new_lu_q;
        new_lv_d     = new_lv_q;
        lu_d         = lu_q;
        lv_d         = lv_q;
        tlu_d        = tlu_q;
        tlv_d        = tlv_q;
        top_u_d      = top_u_q;
        top_v_d      = top_v_q;
        left_u_d     = left_u_q;
        left_v_d     = left_v_q;
        top_left_u_d = top_left_u_q;
        top_left_v_d = top_left_v_q;
        if (state_q == IDLE && (st_start || ld_start)) begin
            cx_d = x;
            cy_d = y;
        end
        // A store captures its edges immediately; a simultaneous load reuses the same x/y.
        if (state_q == IDLE && st_start) begin
            pend_d = ld_start;
            row_d  = {src[1023:960], src[511:448]};
            for (int r = 0; r < 8; r++) begin
                new_lu_d[8*r +: 8] = src[64*r + 56 +: 8];
                new_lv_d[8*r +: 8] = src[512 + 64*r + 56 +: 8];
            end
        end
        if (state_q == ST_DONE) pend_d = 1'b0;
        // The corner comes from the row above, read before this store overwrites it.
        if (state_q == ST_WR && cx_ok) begin
            tlu_d = ram_dout_q[63:56];
            tlv_d = ram_dout_q[127:120];
            lu_d  = new_lu_q;
            lv_d  = new_lv_q;
        end
        if (state_q == LD_CAP) begin
            top_u_d      = (cy_q == 10'd0 || !cx_ok) ? {8{8'd127}} : ram_dout_q[63:0];
            top_v_d      = (cy_q == 10'd0 || !cx_ok) ? {8{8'd127}} : ram_dout_q[127:64];
            left_u_d     = (cx_q == 10'd0) ? {8{8'd129}} : lu_q;
            left_v_d     = (cx_q == 10'd0) ? {8{8'd129}} : lv_q;
            top_left_u_d = (cy_q == 10'd0) ? 8'd127 : (cx_q == 10'd0) ? 8'd129 : tlu_q;
            top_left_v_d = (cy_q == 10'd0) ? 8'd127 : (cx_q == 10'd0) ? 8'd129 : tlv_q;
        end
`ifdef UV_NB_ERR_EN
        err_d = err_q | ((st_start | ld_start) & (busy | ({1'b0, x} >= X_LIM)));
`else
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            row_q        <= '0;
            new_lu_q     <= '0;
            new_lv_q     <= '0;
            lu_q         <= '0;
            lv_q         <= '0;
            tlu_q        <= '0;
            tlv_q        <= '0;
            top_u_q      <= '0;
            top_v_q      <= '0;
            left_u_q     <= '0;
            left_v_q     <= '0;
            top_left_u_q <= '0;
            top_left_v_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            row_q        <= row_d;
            new_lu_q     <= new_lu_d;
            new_lv_q     <= new_lv_d;
            lu_q         <= lu_d;
            lv_q         <= lv_d;
            tlu_q        <= tlu_d;
            tlv_q        <= tlv_d;
            top_u_q      <= top_u_d;
            top_v_q      <= top_v_d;
            left_u_q     <= left_u_d;
            left_v_q     <= left_v_d;
            top_left_u_q <= top_left_u_d;
            top_left_v_q <= top_left_v_d;
            err_q        <= err_d;
        end
    end

    assign top_u      = top_u_q;
    assign top_v      = top_v_q;
    assign left_u     = left_u_q;
    assign left_v     = left_v_q;
    assign top_left_u = top_left_u_q;
    assign top_left_v = top_left_v_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uv_nb_store.sv
// tb_uv_nb_store: directed and raster-order checks of uv_nb_store against a behavioural model.
// Building with UV_NB_ERR_EN switches the expectations to the error-flag variant.
`timescale 1ns/1ps
module tb_uv_nb_store;
    typedef struct packed {
        logic [63:0] tu, tv, lu, lv;
        logic [7:0]  tlu, tlv;
    } ctx_t;

`ifdef UV_NB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, ld_start, st_start;
    logic [9:0]    x, y;
    logic [1023:0] src;
    logic [63:0]   top_u, top_v, left_u, left_v;
    logic [7:0]    top_left_u, top_left_v;
    logic          ld_done, st_done, busy, err;
    logic [2:0]    dbg_state;

    int   total = 0;
    int   bad = 0;
    ctx_t exp_q[$];

    logic [127:0] m_ram [128];
    logic [63:0]  m_lu, m_lv;
    logic [7:0]   m_tlu, m_tlv;

    uv_nb_store #(.MB_W_MAX(128)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .st_start(st_start),
        .x(x), .y(y), .src(src),
        .top_u(top_u), .top_v(top_v), .left_u(left_u), .left_v(left_v),
        .top_left_u(top_left_u), .top_left_v(top_left_v),
        .ld_done(ld_done), .st_done(st_done), .busy(busy), .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] rnd_src();
        logic [1023:0] s;
        for (int i = 0; i < 32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic model_store(input logic [9:0] cx, input logic [1023:0] s);
        logic [6:0] a;
        a = cx[6:0];
        if (!(ERR_EN && cx >= 10'd128)) begin
            m_tlu = m_ram[a][63:56];
            m_tlv = m_ram[a][127:120];
            m_ram[a] = {s[1023:960], s[511:448]};
            for (int r = 0; r < 8; r++) begin
                m_lu[8*r +: 8] = s[8*(8*r+7) +: 8];
                m_lv[8*r +: 8] = s[8*(64+8*r+7) +: 8];
            end
        end
    endtask

    function automatic ctx_t model_ctx(input logic [9:0] cx, input logic [9:0] cy);
        ctx_t c;
        logic top_fill;
        top_fill = (cy == 10'd0) || (ERR_EN && cx >= 10'd128);
        c.tu  = top_fill ? {8{8'd127}} : m_ram[cx[6:0]][63:0];
        c.tv  = top_fill ? {8{8'd127}} : m_ram[cx[6:0]][127:64];
        c.lu  = (cx == 10'd0) ? {8{8'd129}} : m_lu;
        c.lv  = (cx == 10'd0) ? {8{8'd129}} : m_lv;
        c.tlu = (cy == 10'd0) ? 8'd127 : (cx == 10'd0) ? 8'd129 : m_tlu;
        c.tlv = (cy == 10'd0) ? 8'd127 : (cx == 10'd0) ? 8'd129 : m_tlv;
        return c;
    endfunction

    // Issue a store and/or load; poke raises ld_start again while the block is busy.
    task automatic run_cmd(input bit do_st, input bit do_ld, input logic [9:0] cx,
                           input logic [9:0] cy, input logic [1023:0] s, input bit poke);
        int   n, st_n, ld_n, st_cnt, ld_cnt, min_n;
        ctx_t e;
        n = 0; st_n = 0; ld_n = 0; st_cnt = 0; ld_cnt = 0;
        min_n = poke ? 8 : 0;
        if (do_st) model_store(cx, s);
        if (do_ld) exp_q.push_back(model_ctx(cx, cy));
        st_start = do_st; ld_start = do_ld; x = cx; y = cy; src = s;
        while (n < 12 && !((!do_st || st_cnt > 0) && (!do_ld || ld_cnt > 0) && n >= min_n)) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 1) begin
                st_start = 1'b0;
                ld_start = poke;
                x = 10'd5;
                y = 10'd1;
            end
            if (n == 2) ld_start = 1'b0;
            if (st_done) begin
                st_cnt++;
                if (st_n == 0) st_n = n;
            end
            if (ld_done) begin
                ld_cnt++;
                if (ld_n == 0) ld_n = n;
                if (exp_q.size() == 0) begin
                    chk("ld_done_unexpected", ld_done, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("top_u", top_u, e.tu);
                    chk("top_v", top_v, e.tv);
                    chk("left_u", left_u, e.lu);
                    chk("left_v", left_v, e.lv);
                    chk("top_left_u", top_left_u, e.tlu);
                    chk("top_left_v", top_left_v, e.tlv);
                end
            end
        end
        if (do_st) chk("st_latency", st_n, 3);
        else       chk("st_done_count", st_cnt, 0);
        if (do_ld) chk("ld_latency", ld_n, do_st ? 6 : 3);
        else       chk("ld_done_count", ld_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        chk("busy_after", busy, 1'b0);
        chk("done_after", {ld_done, st_done}, 2'b00);
    endtask

    task automatic do_reset();
        st_start = 1'b0;
        ld_start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_lu = '0; m_lv = '0; m_tlu = '0; m_tlv = '0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] s0, s1, s2, sa, sb;
        logic [63:0]   e64;
        int            n, ld_seen;
        rst_n = 1'b0; ld_start = 1'b0; st_start = 1'b0; x = '0; y = '0; src = '0;
        m_lu = '0; m_lv = '0; m_tlu = '0; m_tlv = '0;
        for (int i = 0; i < 128; i++) s0[8*i +: 8] = 8'(i);
        repeat (3) @(negedge clk);
        chk("rst_top_u", top_u, 64'd0);
        chk("rst_left_v", left_v, 64'd0);
        chk("rst_top_left_u", top_left_u, 8'd0);
        chk("rst_flags", {ld_done, st_done, busy, err}, 4'd0);
        chk("rst_state", dbg_state, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load (0,0) straight after reset: both boundaries apply.
        run_cmd(1'b0, 1'b1, 10'd0, 10'd0, '0, 1'b0);
        chk("fill_top_u", top_u, {8{8'd127}});
        chk("fill_left_u", left_u, {8{8'd129}});
        chk("fill_top_left_u", top_left_u, 8'd127);

        run_cmd(1'b1, 1'b0, 10'd0, 10'd0, s0, 1'b0);
        run_cmd(1'b0, 1'b1, 10'd1, 10'd0, '0, 1'b0);
        for (int r = 0; r < 8; r++) e64[8*r +: 8] = 8'(8*r + 7);
        chk("left_u_ramp", left_u, e64);
        for (int r = 0; r < 8; r++) e64[8*r +: 8] = 8'(71 + 8*r);
        chk("left_v_ramp", left_v, e64);

        s1 = rnd_src();
        run_cmd(1'b1, 1'b0, 10'd1, 10'd0, s1, 1'b0);
        s2 = rnd_src();
        run_cmd(1'b1, 1'b0, 10'd0, 10'd1, s2, 1'b0);
        run_cmd(1'b0, 1'b1, 10'd1, 10'd1, '0, 1'b0);
        chk("top_u_mb10", top_u, s1[511:448]);
        chk("top_left_u_mb00", top_left_u, 8'd63);
        run_cmd(1'b0, 1'b1, 10'd0, 10'd1, '0, 1'b0);
        chk("left_x0_row1", left_u, {8{8'd129}});
        chk("top_left_x0_row1", top_left_v, 8'd129);

        // Simultaneous store and load: store first, then the pending load sees it.
        run_cmd(1'b1, 1'b1, 10'd1, 10'd1, rnd_src(), 1'b0);

        // A start during a store is dropped; err only reacts in the checked variant.
        run_cmd(1'b1, 1'b0, 10'd2, 10'd0, rnd_src(), 1'b1);
        chk("err_busy_start", err, ERR_EN);

        do_reset();
        chk("err_after_reset", err, 1'b0);
        chk("left_u_after_reset", left_u, 64'd0);

        // Raster walk: each MB is loaded, then stored, as the picker would.
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                run_cmd(1'b0, 1'b1, 10'(xx), 10'(yy), '0, 1'b0);
                run_cmd(1'b1, 1'b0, 10'(xx), 10'(yy), rnd_src(), 1'b0);
            end
        end

        // Reset in the middle of a load: no done pulse, RAM keeps its contents.
        ld_start = 1'b1; x = 10'd2; y = 10'd1;
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_lu = '0; m_lv = '0; m_tlu = '0; m_tlv = '0;
        ld_seen = 0;
        n = 0;
        while (n < 6) begin
            @(negedge clk);
            if (ld_done) ld_seen++;
            n++;
        end
        chk("abort_no_ld_done", ld_seen, 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_top_u", top_u, 64'd0);
        run_cmd(1'b0, 1'b1, 10'd1, 10'd1, '0, 1'b0);

        // Column 200 either aliases onto entry 72 or is rejected with err.
        do_reset();
        chk("err_clear", err, 1'b0);
        sa = rnd_src();
        run_cmd(1'b1, 1'b0, 10'd72, 10'd0, sa, 1'b0);
        run_cmd(1'b1, 1'b0, 10'd72, 10'd0, sa, 1'b0);
        sb = rnd_src();
        run_cmd(1'b1, 1'b0, 10'd200, 10'd1, sb, 1'b0);
        chk("err_range", err, ERR_EN);
        run_cmd(1'b0, 1'b1, 10'd72, 10'd1, '0, 1'b0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uv_nb_store.md
# uv_nb_store

Chroma neighbour store for the VP8 macroblock pipeline. It captures each reconstructed 8x8 U/V macroblock that the UV mode picker emits and keeps the edge samples that the next prediction needs. Before a macroblock is predicted, it supplies the prediction context: top row, left column and top-left corner for U and V. It sits in a loop between the UV mode picker's reconstructed output and that picker's predictor inputs.

## Interface
- MB_W_MAX, 128: maximum macroblocks per row; depth of the top-row RAM. AW = clog2(MB_W_MAX).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_start  in  1  single-cycle load request for macroblock (x,y).
- st_start  in  1  single-cycle store request for macroblock (x,y).
- x  in  10  macroblock column; sampled on the accepted start.
- y  in  10  macroblock row; sampled on the accepted start.
- src  in  1024  reconstructed U/V macroblock, sampled on st_start.
  - Bytes 0..63 are U, row-major; bytes 64..127 are V.
  - Byte i occupies bits [8i+7:8i].
- top_u, top_v  out  64  byte c = column c of the row above.
- left_u, left_v  out  64  byte r = row r of the column to the left.
- top_left_u, top_left_v  out  8  corner samples.
- ld_done  out  1  one-cycle pulse; context outputs are valid from this cycle until the next accepted ld_start.
- st_done  out  1  one-cycle pulse; the store has been committed.
- busy  out  1  high while not IDLE.
- err  out  1  sticky error flag; see Configuration.

## Operation
- Top RAM: MB_W_MAX x 128 bits, built internally, synchronous read with 1-cycle latency.
  - Entry x holds the bottom row of the last stored macroblock in column x.
  - Bits [63:0] = U bytes 56..63; bits [127:64] = V bytes 120..127.
- Left registers: 64 bits each for U and V, loaded on store.
  - U: byte r = src byte 8r+7.
  - V: byte r = src byte 64+8r+7.
- Corner registers: tl_u and tl_v.
- FSM states: IDLE, LD_RD, LD_CAP, LD_DONE, ST_RD, ST_WR, ST_DONE.
- Store path: IDLE, then ST_RD, ST_WR, ST_DONE, then IDLE.
  - ST_RD: read RAM[x].
  - ST_WR: tl_u <= old dout[63:56] and tl_v <= old dout[127:120], both captured before the overwrite. Then write the new bottom row to RAM[x] and load the left registers.
- Load path: IDLE, then LD_RD, LD_CAP, LD_DONE, then IDLE.
  - LD_RD: read RAM[x].
  - LD_CAP: register the outputs with these boundary rules:
  - top: y==0 gives all bytes 127; otherwise RAM dout.
  - left: x==0 gives all bytes 129; otherwise the left registers.
  - top_left: y==0 gives 127; else x==0 gives 129; else tl_u / tl_v.
- Start arbitration:
  - A start is accepted only in IDLE.
  - If both starts are high in IDLE, the store runs first. The load is latched as pending, with its x and y taken from the same cycle, and begins in the cycle after ST_DONE.
  - A start that arrives while busy is ignored.
- A store must precede the load of the following macroblock in raster order.
  - The left column of MB (x,y) is the column stored by MB (x-1,y).
  - The corner of MB (x,y) is the corner captured by that same store, which read RAM[x-1] as written by row y-1.

## Timing
- Load: ld_start sampled at cycle T; ld_done is high at T+3 and the outputs change at T+3.
- Store: st_start sampled at T; RAM write and left/corner update at T+2; st_done high at T+3.
- A combined store and pending load ends with ld_done at T+6.
- Back-to-back operation: a new start is accepted at T+4, in the first IDLE cycle.
- Reset values:
  - All outputs 0 and busy 0.
  - FSM in IDLE, pending flag clear.
  - Left and corner registers 0.
  - RAM contents undefined; not cleared.
- Reset in mid-operation aborts the operation immediately. No done pulse is generated, and a RAM write issued before the reset is not rolled back.

## Configuration
- UV_NB_ERR_EN defined:
  - A command with x >= MB_W_MAX completes with its normal done timing. It performs no RAM access and no register update, and load outputs use top = 127. err is set.
  - A start ignored while busy also sets err.
  - err stays set until reset.
- UV_NB_ERR_EN undefined:
  - err is tied to 0.
  - The RAM address is x[AW-1:0], so out-of-range columns alias.
  - Starts while busy are silently ignored.

## Test plan
- Load (0,0) after reset: ld_done at T+3; top bytes all 127, left bytes all 129, top_left_u = 127.
- Store (0,0) with src byte i = i, then load (1,0):
  - left_u byte r = 8r+7.
  - left_v byte r = 71+8r.
  - top = 127, top_left = 127.
- Store row 0, MBs 0..1, with distinct patterns. Then store (0,1) and load (1,1):
  - top_u = MB(1,0) bytes 56..63.
  - top_left_u = byte 63 of MB(0,0).
- Load (0,1): left = 129 and top_left = 129.
- ld_start and st_start in the same cycle: st_done at T+3, ld_done at T+6, and the load reflects the just-stored data.
- With UV_NB_ERR_EN: store at x = 200 with MB_W_MAX = 128 gives st_done at T+3, err = 1, and RAM[72] unchanged. A start while busy also sets err.
